// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE job controller.
// Job bundle, controller state encoding, event indices.
package redmule_pkg;

  localparam int unsigned REDMULE_REGS = 2;
  localparam int unsigned N_CORES = 8;
  localparam int unsigned IdW = $clog2(N_CORES);
  localparam int unsigned JobWidth = 32 * REDMULE_REGS;

  localparam int unsigned EvtDone = 0;
  localparam int unsigned EvtErr = 1;

  typedef struct packed {
    logic [IdW-1:0]      owner;
    logic [JobWidth-1:0] payload;
  } job_t;

  typedef enum logic [2:0] {
    LATCH_RST = 3'd0,
    IDLE      = 3'd1,
    CONFIG    = 3'd2,
    STARTING  = 3'd3,
    COMPUTING = 3'd4,
    FINISHED  = 3'd5,
    ABORT     = 3'd6
  } redmule_job_ctrl_state_e;

endpackage

// File: rtl/redmule_job_fifo.sv
// Pending-job FIFO: power-of-2 ring buffer with occupancy count.
// Synchronous clear empties it without touching storage.
module redmule_job_fifo
  import redmule_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  job_t                   data_i,
  input  logic                   pop_i,
  output job_t                   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  job_t            mem [Depth];
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [CntW-1:0] cnt_q;

  // pointer and count update; pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i) cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  // payload storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem[wr_q] <= data_i;
  end

  assign data_o  = mem[rd_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/redmule_job_ctrl.sv
// Multi-job RedMulE controller: job queue, run FSM,
// watchdog abort and per-owner done/error events.
module redmule_job_ctrl
  import redmule_pkg::*;
#(
  parameter int unsigned QueueDepth    = 4,
  parameter int unsigned TimeoutCycles = 65536,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        test_mode_i,
  input  logic                        job_valid_i,
  output logic                        job_ready_o,
  input  job_t                        job_i,
  output logic                        cfg_start_o,
  output logic [JobWidth-1:0]         cfg_o,
  input  logic                        cfg_valid_i,
  input  logic                        w_loaded_i,
  input  logic                        z_done_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        idle_o,
  output logic                        first_load_o,
  output logic                        flush_o,
  output logic                        sched_rst_o,
  output logic [N_CORES-1:0][1:0]     evt_o,
  output logic [$clog2(QueueDepth):0] pending_o,
  output logic [CntWidth-1:0]         done_cnt_o
);

  localparam bit WdEn = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] WdLimit =
    CntWidth'(WdEn ? TimeoutCycles - 1 : 0);

  redmule_job_ctrl_state_e state_q, state_d;

  job_t                head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                active;
  logic                wd_hit;
  logic [IdW-1:0]      owner_q;
  logic [JobWidth-1:0] cfg_q;
  logic                cfg_start_q;
  logic [CntWidth-1:0] wd_q;
  logic [CntWidth-1:0] done_q;

  assign push = job_valid_i && !full && !clear_i;
  assign pop  = (state_q == IDLE) && !empty && !clear_i;

  redmule_job_fifo #(
    .Depth (QueueDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (job_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (pending_o)
  );

  assign active = (state_q == CONFIG) ||
                  (state_q == STARTING) ||
                  (state_q == COMPUTING);
  assign wd_hit = WdEn && (wd_q == WdLimit);

  // next-state logic; abort beats any forward progress
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LATCH_RST: state_d = IDLE;
      IDLE: begin
        if (!empty) state_d = CONFIG;
        else if (test_mode_i) state_d = STARTING;
      end
      CONFIG: begin
        if (abort_i || wd_hit) state_d = ABORT;
        else if (cfg_valid_i) state_d = STARTING;
      end
      STARTING: begin
        if (abort_i || wd_hit) state_d = ABORT;
        else if (w_loaded_i) state_d = COMPUTING;
      end
      COMPUTING: begin
        if (abort_i || wd_hit) state_d = ABORT;
        else if (z_done_i) state_d = FINISHED;
      end
      FINISHED: state_d = IDLE;
      ABORT:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // state, active job and start pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LATCH_RST;
      owner_q     <= '0;
      cfg_q       <= '0;
      cfg_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_start_q <= pop;
      if (pop) begin
        owner_q <= head.owner;
        cfg_q   <= head.payload;
      end else if (state_q == IDLE && state_d == STARTING) begin
        owner_q <= '0;
        cfg_q   <= '0;
      end
    end
  end

  // watchdog: zero outside a job, saturating count inside
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (clear_i || !active || !WdEn) begin
      wd_q <= '0;
    end else if (wd_q != '1) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // completed-job counter survives soft clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
    end else if (state_q == FINISHED && !clear_i) begin
      done_q <= done_q + 1'b1;
    end
  end

  // one-cycle done/error event towards the job owner
  always_comb begin
    evt_o = '0;
    if (!clear_i) begin
      if (state_q == FINISHED) evt_o[owner_q][EvtDone] = 1'b1;
      if (state_q == ABORT) evt_o[owner_q][EvtErr] = 1'b1;
    end
  end

  assign job_ready_o  = !full;
  assign cfg_start_o  = cfg_start_q;
  assign cfg_o        = cfg_q;
  assign busy_o       = (state_q == STARTING) || (state_q == COMPUTING);
  assign idle_o       = (state_q == IDLE) && empty;
  assign first_load_o = (state_q == STARTING);
  assign flush_o      = (state_q == FINISHED) || (state_q == ABORT);
  assign sched_rst_o  = flush_o;
  assign done_cnt_o   = done_q;

endmodule

// File: tb/tb_redmule_job_ctrl.sv
// Bench for redmule_job_ctrl: job-level reference model,
// directed scenarios and randomized traffic.
module tb_redmule_job_ctrl;
  import redmule_pkg::*;

  localparam int unsigned QD = 4;
  localparam int unsigned TO = 32;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear, test_mode, job_valid;
  logic cfg_valid, w_loaded, z_done, abort;
  job_t job;

  logic                    job_ready_o, cfg_start_o;
  logic [JobWidth-1:0]     cfg_o;
  logic                    busy_o, idle_o, first_load_o;
  logic                    flush_o, sched_rst_o;
  logic [N_CORES-1:0][1:0] evt_o;
  logic [$clog2(QD):0]     pending_o;
  logic [CW-1:0]           done_cnt_o;

  always #5 clk = ~clk;

  redmule_job_ctrl #(
    .QueueDepth    (QD),
    .TimeoutCycles (TO),
    .CntWidth      (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .test_mode_i  (test_mode),
    .job_valid_i  (job_valid),
    .job_ready_o  (job_ready_o),
    .job_i        (job),
    .cfg_start_o  (cfg_start_o),
    .cfg_o        (cfg_o),
    .cfg_valid_i  (cfg_valid),
    .w_loaded_i   (w_loaded),
    .z_done_i     (z_done),
    .abort_i      (abort),
    .busy_o       (busy_o),
    .idle_o       (idle_o),
    .first_load_o (first_load_o),
    .flush_o      (flush_o),
    .sched_rst_o  (sched_rst_o),
    .evt_o        (evt_o),
    .pending_o    (pending_o),
    .done_cnt_o   (done_cnt_o)
  );

  int n_tests = 0;
  int n_fail = 0;

  // reference model: job queue plus the phase of the active job
  typedef enum {P_RST, P_IDLE, P_CFG, P_START, P_COMP, P_FIN, P_ABT} phase_e;
  phase_e              ph;
  job_t                mq[$];
  logic [IdW-1:0]      m_own;
  logic [JobWidth-1:0] m_cfg;
  bit                  m_cs;
  int                  m_t0;
  int                  cyc;
  logic [CW-1:0]       m_done;
  bit                  m_pushed;
  logic [JobWidth-1:0] starts[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    ph = P_RST;
    mq.delete();
    m_own = '0;
    m_cfg = '0;
    m_cs = 1'b0;
    m_done = '0;
    m_t0 = 0;
    cyc = 0;
  endfunction

  task automatic idle_in();
    clear = 0; test_mode = 0; job_valid = 0;
    cfg_valid = 0; w_loaded = 0; z_done = 0; abort = 0;
  endtask

  // compare this cycle's outputs, then advance the model one clock
  task automatic step();
    logic [2*N_CORES-1:0] exp_evt;
    bit act, tmo;
    job_t j;
    #1;
    exp_evt = '0;
    if (!clear && ph == P_FIN) exp_evt[int'(m_own) * 2] = 1'b1;
    if (!clear && ph == P_ABT) exp_evt[int'(m_own) * 2 + 1] = 1'b1;
    chk("job_ready", job_ready_o, mq.size() < QD);
    chk("pending", pending_o, mq.size());
    chk("idle", idle_o, ph == P_IDLE && mq.size() == 0);
    chk("busy", busy_o, ph == P_START || ph == P_COMP);
    chk("first_load", first_load_o, ph == P_START);
    chk("flush", flush_o, ph == P_FIN || ph == P_ABT);
    chk("sched_rst", sched_rst_o, ph == P_FIN || ph == P_ABT);
    chk("cfg_start", cfg_start_o, m_cs);
    chk("cfg", cfg_o, m_cfg);
    chk("evt", evt_o, exp_evt);
    chk("done_cnt", done_cnt_o, m_done);
    if (cfg_start_o) starts.push_back(cfg_o);

    act = (ph == P_CFG || ph == P_START || ph == P_COMP);
    tmo = act && (cyc - m_t0 == int'(TO) - 1);
    m_pushed = job_valid && mq.size() < QD && !clear;
    if (clear) begin
      mq.delete();
      ph = P_IDLE;
      m_cs = 1'b0;
    end else begin
      m_cs = 1'b0;
      case (ph)
        P_RST: ph = P_IDLE;
        P_IDLE: begin
          if (mq.size() > 0) begin
            j = mq.pop_front();
            m_own = j.owner;
            m_cfg = j.payload;
            m_cs = 1'b1;
            ph = P_CFG;
            m_t0 = cyc + 1;
          end else if (test_mode) begin
            m_own = '0;
            m_cfg = '0;
            ph = P_START;
            m_t0 = cyc + 1;
          end
        end
        P_FIN: begin
          m_done++;
          ph = P_IDLE;
        end
        P_ABT: ph = P_IDLE;
        default: begin
          if (abort || tmo) ph = P_ABT;
          else if (ph == P_CFG && cfg_valid) ph = P_START;
          else if (ph == P_START && w_loaded) ph = P_COMP;
          else if (ph == P_COMP && z_done) ph = P_FIN;
        end
      endcase
      if (m_pushed) mq.push_back(job);
    end
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic push_job(int owner, logic [JobWidth-1:0] pl);
    idle_in();
    job.owner = IdW'(owner);
    job.payload = pl;
    job_valid = 1;
    step();
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    rst_ni = 0;
    repeat (3) @(negedge clk);
    rst_ni = 1;
    #1;
    model_reset();
  endtask

  initial begin
    int n;
    logic [CW-1:0] d0;
    job_t pushed[$];
    idle_in();
    job = '0;
    do_reset();

    // reset values, still in LATCH_RST
    chk("rst_ready", job_ready_o, 1);
    chk("rst_idle", idle_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_cnt_o, 0);
    chk("rst_evt", evt_o, 0);
    step();
    chk("rst_idle_after", idle_o, 1);

    // single job for owner 3
    push_job(3, 64'h0123_4567_89ab_cdef);
    step();
    cfg_valid = 1; step(); idle_in();
    step(); step();
    w_loaded = 1; step(); idle_in();
    repeat (14) step();
    z_done = 1; step(); idle_in();
    chk("t1_evt_done", evt_o[3][0], 1);
    chk("t1_evt_err", evt_o[3][1], 0);
    step();
    chk("t1_evt_gone", evt_o[3][0], 0);
    chk("t1_done_cnt", done_cnt_o, 1);
    chk("t1_idle", idle_o, 1);

    // fill the queue behind an active job, then drain in order
    starts.delete();
    pushed.delete();
    job.owner = 3'd1; job.payload = 64'h1000;
    pushed.push_back(job);
    push_job(1, 64'h1000);
    step();
    for (int i = 1; i <= 4; i++) begin
      job.owner = IdW'(i); job.payload = 64'h1000 + 64'(i);
      pushed.push_back(job);
      push_job(i, 64'h1000 + 64'(i));
    end
    chk("fill_ready", job_ready_o, 0);
    chk("fill_pending", pending_o, 4);
    job.owner = 3'd5; job.payload = 64'h1005;
    pushed.push_back(job);
    job_valid = 1;
    step();
    chk("fill_held", pending_o, 4);
    cfg_valid = 1; w_loaded = 1; z_done = 1;
    n = 0;
    while (!(starts.size() == 6 && idle_o) && n < 300) begin
      step();
      if (m_pushed) job_valid = 0;
      n++;
    end
    idle_in();
    chk("drain_timeout", n < 300, 1);
    chk("drain_count", starts.size(), 6);
    for (int i = 0; i < 6 && i < starts.size(); i++)
      chk("drain_order", starts[i], pushed[i].payload);
    chk("drain_done_cnt", done_cnt_o, 7);

    // watchdog: W tile never arrives
    d0 = done_cnt_o;
    push_job(5, 64'hdead);
    step();
    cfg_valid = 1;
    n = 0;
    while (!flush_o && n < 200) begin
      step();
      n++;
    end
    idle_in();
    chk("wd_latency", n, TO);
    chk("wd_evt_err", evt_o[5][1], 1);
    chk("wd_evt_done", evt_o[5][0], 0);
    step();
    chk("wd_done_cnt", done_cnt_o, d0);

    // abort and z_done together while computing
    push_job(6, 64'hbeef);
    step();
    cfg_valid = 1; step(); idle_in();
    w_loaded = 1; step(); idle_in();
    chk("ab_busy", busy_o && !first_load_o, 1);
    abort = 1; z_done = 1; step(); idle_in();
    chk("ab_evt_err", evt_o[6][1], 1);
    chk("ab_evt_done", evt_o[6][0], 0);
    chk("ab_flush", flush_o, 1);
    step();
    chk("ab_done_cnt", done_cnt_o, d0);

    // soft clear with two jobs still queued
    push_job(2, 64'ha);
    push_job(4, 64'hb);
    push_job(7, 64'hc);
    cfg_valid = 1; step(); idle_in();
    w_loaded = 1; step(); idle_in();
    chk("clr_pending_pre", pending_o, 2);
    clear = 1; step(); idle_in();
    chk("clr_idle", idle_o, 1);
    chk("clr_pending", pending_o, 0);
    chk("clr_evt", evt_o, 0);
    step();
    chk("clr_evt_after", evt_o, 0);
    chk("clr_done_kept", done_cnt_o, d0);

    // test mode bypasses CONFIG
    test_mode = 1; step(); idle_in();
    chk("tm_first_load", first_load_o, 1);
    chk("tm_cfg_start", cfg_start_o, 0);
    w_loaded = 1; step(); idle_in();
    z_done = 1; step(); idle_in();
    chk("tm_evt_owner0", evt_o[0][0], 1);
    step();

    // asynchronous reset in the middle of a job
    push_job(1, 64'h77);
    step();
    rst_ni = 0;
    #2;
    chk("arst_done", done_cnt_o, 0);
    chk("arst_pending", pending_o, 0);
    chk("arst_ready", job_ready_o, 1);
    @(negedge clk);
    rst_ni = 1;
    #1;
    model_reset();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      job_valid = ($urandom_range(0, 99) < 40);
      job.owner = IdW'($urandom_range(0, N_CORES - 1));
      job.payload = {$urandom, $urandom};
      cfg_valid = ($urandom_range(0, 99) < 30);
      w_loaded = ($urandom_range(0, 99) < 30);
      z_done = ($urandom_range(0, 99) < 25);
      abort = ($urandom_range(0, 99) < 2);
      clear = ($urandom_range(0, 199) == 0);
      test_mode = ($urandom_range(0, 99) < 5);
      step();
    end
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
